// File: rtl/mem_pkg.sv
// Shared types for the processor memory bus endpoint: bus command encoding,
// tag width and the per-tag tracking entry.
package mem_pkg;

  localparam int unsigned MEM_TAG_W = 4;
  // Countdown field width; LATENCY must fit in MEM_CNT_W bits.
  localparam int unsigned MEM_CNT_W = 8;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_e;

  typedef struct packed {
    logic                 valid;
    logic [MEM_CNT_W-1:0] countdown;
    logic [31:0]          data;
  } mem_entry_t;

endpackage

// File: rtl/mem_tag_tracker.sv
// Per-tag entry array: lowest-free-tag allocation, countdown and selection
// of the (single) completing entry for the next cycle.
module mem_tag_tracker
  import mem_pkg::*;
#(
  parameter int unsigned NUM_TAGS = 15,
  parameter int unsigned LATENCY  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alloc,
  input  logic [31:0]          alloc_data,
  output logic [MEM_TAG_W-1:0] free_tag,
  output logic [MEM_TAG_W-1:0] cmpl_tag,
  output logic [31:0]          cmpl_data
);

  mem_entry_t          entries_q [1:NUM_TAGS];
  mem_entry_t          entries_d [1:NUM_TAGS];
  logic [NUM_TAGS:1]   done_vec;

  always_comb begin
    free_tag = '0;
    for (int unsigned i = NUM_TAGS; i >= 1; i--) begin
      if (!entries_q[i].valid) free_tag = MEM_TAG_W'(i);
    end
  end

  // The decrement of the acceptance edge is folded into the load value, so an
  // entry holds countdown==0 in its completion cycle and is freed at its end.
  always_comb begin
    for (int unsigned i = 1; i <= NUM_TAGS; i++) begin
      entries_d[i] = entries_q[i];
      if (entries_q[i].valid) begin
        if (entries_q[i].countdown == '0) entries_d[i] = '0;
        else entries_d[i].countdown = entries_q[i].countdown - 1'b1;
      end
      if (alloc && (free_tag == MEM_TAG_W'(i))) begin
        entries_d[i].valid     = 1'b1;
        entries_d[i].countdown = MEM_CNT_W'(LATENCY - 1);
        entries_d[i].data      = alloc_data;
      end
    end
  end

  // Completion is picked from next state so the output register shows it in
  // exactly cycle n+LATENCY (including LATENCY==1).
  always_comb begin
    cmpl_tag  = '0;
    cmpl_data = '0;
    done_vec  = '0;
    for (int unsigned i = 1; i <= NUM_TAGS; i++) begin
      if (entries_d[i].valid && (entries_d[i].countdown == '0)) begin
        done_vec[i] = 1'b1;
        cmpl_tag    = MEM_TAG_W'(i);
        cmpl_data   = entries_d[i].data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 1; i <= NUM_TAGS; i++) entries_q[i] <= '0;
    end else begin
      for (int unsigned i = 1; i <= NUM_TAGS; i++) entries_q[i] <= entries_d[i];
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) assert ($countones(done_vec) <= 1);
  end
`endif

endmodule

// File: rtl/mem_responder.sv
// Bus-side memory endpoint: word array, acceptance checks, tagged completions
// after a fixed latency. Optional counters under MEM_RESPONDER_STATS_EN.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 16384,
  parameter int unsigned NUM_TAGS  = 15,
  parameter int unsigned LATENCY   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           proc2mem_command,
  input  logic [31:0]          proc2mem_addr,
  input  logic [31:0]          proc2mem_data,
  output logic [MEM_TAG_W-1:0] mem2proc_response,
  output logic [31:0]          mem2proc_data,
  output logic [MEM_TAG_W-1:0] mem2proc_tag
`ifdef MEM_RESPONDER_STATS_EN
  ,
  output logic [31:0]          stat_loads,
  output logic [31:0]          stat_stores,
  output logic [31:0]          stat_rejects
`endif
);

  localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [31:0]          mem [MEM_WORDS];
  logic [IDX_W-1:0]     word_idx;
  logic                 is_load;
  logic                 is_store;
  logic                 in_range;
  logic                 accept;
  logic                 mem_we;
  logic [31:0]          alloc_data;
  logic [MEM_TAG_W-1:0] free_tag;
  logic [MEM_TAG_W-1:0] cmpl_tag;
  logic [31:0]          cmpl_data;
  logic [MEM_TAG_W-1:0] tag_q, tag_d;
  logic [31:0]          data_q, data_d;

  always_comb begin
    is_load    = (proc2mem_command == BUS_LOAD);
    is_store   = (proc2mem_command == BUS_STORE);
    in_range   = ({2'b00, proc2mem_addr[31:2]} < MEM_WORDS);
    word_idx   = proc2mem_addr[IDX_W+1:2];
    accept     = rst && (is_load || is_store) && (proc2mem_addr[1:0] == 2'b00)
                 && in_range && (free_tag != '0);
    mem_we     = accept && is_store;
    alloc_data = is_load ? mem[word_idx] : '0;
    mem2proc_response = accept ? free_tag : '0;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[word_idx] <= proc2mem_data;
  end

  mem_tag_tracker #(
    .NUM_TAGS (NUM_TAGS),
    .LATENCY  (LATENCY)
  ) u_tracker (
    .clk        (clk),
    .rst_n      (rst),
    .alloc      (accept),
    .alloc_data (alloc_data),
    .free_tag   (free_tag),
    .cmpl_tag   (cmpl_tag),
    .cmpl_data  (cmpl_data)
  );

  always_comb begin
    tag_d  = cmpl_tag;
    data_d = cmpl_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_q  <= '0;
      data_q <= '0;
    end else begin
      tag_q  <= tag_d;
      data_q <= data_d;
    end
  end

  assign mem2proc_tag  = tag_q;
  assign mem2proc_data = data_q;

`ifdef MEM_RESPONDER_STATS_EN
  logic [31:0] loads_q, loads_d;
  logic [31:0] stores_q, stores_d;
  logic [31:0] rejects_q, rejects_d;

  always_comb begin
    loads_d   = loads_q;
    stores_d  = stores_q;
    rejects_d = rejects_q;
    if (accept && is_load)  loads_d  = loads_q + 32'd1;
    if (accept && is_store) stores_d = stores_q + 32'd1;
    if (!accept && (proc2mem_command != BUS_NONE)) rejects_d = rejects_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      loads_q   <= '0;
      stores_q  <= '0;
      rejects_q <= '0;
    end else begin
      loads_q   <= loads_d;
      stores_q  <= stores_d;
      rejects_q <= rejects_d;
    end
  end

  assign stat_loads   = loads_q;
  assign stat_stores  = stores_q;
  assign stat_rejects = rejects_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: two instances (LATENCY 4 / 15 tags and
// LATENCY 20 / 3 tags) share one stimulus stream checked against a tag model.
`timescale 1ns/1ps
module tb_mem_responder;
  import mem_pkg::*;

  localparam int unsigned WORDS = 16384;
  localparam int          WIN   = 64;
  localparam int          LAT [2] = '{4, 20};
  localparam int          NT  [2] = '{15, 3};

  typedef struct {
    int          cyc;
    logic [3:0]  tag;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [1:0]  cmd;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  resp [2];
  logic [3:0]  tag  [2];
  logic [31:0] rdata [2];
`ifdef MEM_RESPONDER_STATS_EN
  logic [31:0] sl [2];
  logic [31:0] ss [2];
  logic [31:0] sr [2];
`endif

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] mm      [2][WIN+1];
  bit          busy    [2][16];
  int          done_at [2][16];
  int unsigned ml [2];
  int unsigned ms [2];
  int unsigned mr [2];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  mem_responder #(.MEM_WORDS(WORDS), .NUM_TAGS(15), .LATENCY(4)) dut0 (
    .clk(clk), .rst(rst), .proc2mem_command(cmd), .proc2mem_addr(addr),
    .proc2mem_data(wdata), .mem2proc_response(resp[0]),
    .mem2proc_data(rdata[0]), .mem2proc_tag(tag[0])
`ifdef MEM_RESPONDER_STATS_EN
    , .stat_loads(sl[0]), .stat_stores(ss[0]), .stat_rejects(sr[0])
`endif
  );

  mem_responder #(.MEM_WORDS(WORDS), .NUM_TAGS(3), .LATENCY(20)) dut1 (
    .clk(clk), .rst(rst), .proc2mem_command(cmd), .proc2mem_addr(addr),
    .proc2mem_data(wdata), .mem2proc_response(resp[1]),
    .mem2proc_data(rdata[1]), .mem2proc_tag(tag[1])
`ifdef MEM_RESPONDER_STATS_EN
    , .stat_loads(sl[1]), .stat_stores(ss[1]), .stat_rejects(sr[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int slot(input int w);
    return (w == int'(WORDS) - 1) ? WIN : w;
  endfunction

  function automatic void chk(input string name, input int k,
                              input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, k, act, expv, cyc);
    end
  endfunction

  function automatic void reset_model(input int k);
    for (int i = 0; i < 16; i++) busy[k][i] = 1'b0;
    if (k == 0) q0.delete(); else q1.delete();
    ml[k] = 0; ms[k] = 0; mr[k] = 0;
  endfunction

  // Tag is free once its completion cycle has passed; lowest free tag wins.
  function automatic logic [3:0] model_step(input int k, input logic [1:0] c,
                                            input logic [31:0] a, input logic [31:0] d);
    int   w;
    int   t;
    exp_t e;
    w = int'(a >> 2);
    t = 0;
    if ((c == 2'd1 || c == 2'd2) && a[1:0] == 2'b00 && w < int'(WORDS)) begin
      for (int i = 1; i <= NT[k]; i++) begin
        if (!busy[k][i] || done_at[k][i] < cyc) begin
          t = i;
          break;
        end
      end
    end
    if (t == 0) begin
      if (c != 2'd0) mr[k]++;
      return 4'd0;
    end
    busy[k][t]    = 1'b1;
    done_at[k][t] = cyc + LAT[k];
    e.cyc  = cyc + LAT[k];
    e.tag  = t[3:0];
    e.data = (c == 2'd1) ? mm[k][slot(w)] : 32'd0;
    if (c == 2'd2) begin
      mm[k][slot(w)] = d;
      ms[k]++;
    end else begin
      ml[k]++;
    end
    if (k == 0) q0.push_back(e); else q1.push_back(e);
    return t[3:0];
  endfunction

  task automatic step(input logic r, input logic [1:0] c,
                      input logic [31:0] a, input logic [31:0] d);
    logic [3:0] er;
    @(posedge clk);
    #1;
    rst = r; cmd = c; addr = a; wdata = d;
    #1;
    for (int k = 0; k < 2; k++) begin
      if (!r) reset_model(k);
`ifdef MEM_RESPONDER_STATS_EN
      chk("stat_loads", k, sl[k], ml[k]);
      chk("stat_stores", k, ss[k], ms[k]);
      chk("stat_rejects", k, sr[k], mr[k]);
`endif
      er = r ? model_step(k, c, a, d) : 4'd0;
      chk("response", k, {28'd0, resp[k]}, {28'd0, er});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, BUS_NONE, $urandom, $urandom);
  endtask

  function automatic void mon(input int k, input logic [3:0] t, input logic [31:0] d);
    exp_t e;
    int   sz;
    sz = (k == 0) ? q0.size() : q1.size();
    if (t != 4'd0) begin
      checks++;
      if (sz == 0) begin
        errors++;
        $display("FAIL completion dut%0d: got tag %0d data 0x%0h, expected none (cycle %0d)",
                 k, t, d, cyc);
      end else begin
        if (k == 0) e = q0.pop_front(); else e = q1.pop_front();
        if (e.tag !== t || e.data !== d || e.cyc != cyc) begin
          errors++;
          $display("FAIL completion dut%0d: got tag %0d data 0x%0h cycle %0d, expected tag %0d data 0x%0h cycle %0d",
                   k, t, d, cyc, e.tag, e.data, e.cyc);
        end
      end
    end else begin
      checks++;
      if (d !== 32'd0) begin
        errors++;
        $display("FAIL idle_data dut%0d: got 0x%0h, expected 0x0 (cycle %0d)", k, d, cyc);
      end
      if (sz != 0) begin
        if (k == 0) e = q0[0]; else e = q1[0];
        if (e.cyc <= cyc) begin
          checks++;
          errors++;
          $display("FAIL completion_missing dut%0d: got tag 0, expected tag %0d (cycle %0d)",
                   k, e.tag, cyc);
          if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
      end
    end
  endfunction

  always @(negedge clk) begin
    mon(0, tag[0], rdata[0]);
    mon(1, tag[1], rdata[1]);
  end

  initial begin
    logic [31:0] v;
    logic [31:0] a;
    logic [1:0]  c;
    logic        r;
    int          p;
    rst = 1'b1; cmd = BUS_NONE; addr = '0; wdata = '0;
    for (int k = 0; k < 2; k++) reset_model(k);
    #1 rst = 1'b0;
    for (int i = 0; i <= WIN; i++) begin
      v = (i == 16) ? 32'hDEADBEEF : $urandom;
      mm[0][i] = v;
      mm[1][i] = v;
      if (i == WIN) begin
        dut0.mem[WORDS-1] = v;
        dut1.mem[WORDS-1] = v;
      end else begin
        dut0.mem[i] = v;
        dut1.mem[i] = v;
      end
    end
    step(1'b0, BUS_LOAD, 32'h40, 0);
    step(1'b0, BUS_NONE, 0, 0);
    idle(2);

    step(1'b1, BUS_LOAD, 32'h40, 0);
    idle(6);
    step(1'b1, BUS_STORE, 32'h80, 32'h12345678);
    step(1'b1, BUS_LOAD, 32'h80, 0);
    idle(6);
    step(1'b1, BUS_LOAD, 32'h40, 0);
    step(1'b1, BUS_STORE, 32'h40, 32'h0);
    idle(25);

    for (int i = 0; i < 6; i++) step(1'b1, BUS_LOAD, 32'h44, 0);
    idle(14);
    step(1'b1, BUS_LOAD, 32'h48, 0);
    step(1'b1, BUS_LOAD, 32'h4C, 0);
    idle(25);

    step(1'b1, BUS_LOAD, 32'h41, 0);
    step(1'b1, BUS_STORE, 32'h10000, 32'hCAFEF00D);
    step(1'b1, 2'd3, 32'h40, 32'h55555555);
    step(1'b1, BUS_STORE, 32'h42, 32'hAAAAAAAA);
    step(1'b1, BUS_LOAD, 32'h40, 0);
    step(1'b1, BUS_LOAD, 32'hFFFC, 0);
    idle(25);

    step(1'b1, BUS_LOAD, 32'h40, 0);
    step(1'b1, BUS_LOAD, 32'h44, 0);
    step(1'b0, BUS_NONE, 0, 0);
    step(1'b0, BUS_LOAD, 32'h40, 0);
    step(1'b1, BUS_LOAD, 32'h48, 0);
    idle(25);

    for (int n = 0; n < 1500; n++) begin
      p = $urandom_range(0, 99);
      c = (p < 30) ? 2'd0 : (p < 65) ? 2'd1 : (p < 90) ? 2'd2 : 2'd3;
      a = 32'($urandom_range(0, WIN - 1)) << 2;
      p = $urandom_range(0, 19);
      if (p == 0)      a = a | 32'($urandom_range(1, 3));
      else if (p == 1) a = 32'h10000 + (32'($urandom_range(0, 255)) << 2);
      else if (p == 2) a = 32'hFFFC;
      else if (p == 3) a = ($urandom | 32'h0004_0000) & ~32'h3;
      r = ($urandom_range(0, 299) != 0);
      step(r, c, a, $urandom);
    end
    idle(30);

    checks++;
    if (q0.size() != 0) begin
      errors++;
      $display("FAIL drain dut0: got %0d pending, expected 0", q0.size());
    end
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL drain dut1: got %0d pending, expected 0", q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
